fpu_driver: RTL and testbench

- Bus-master front end that sits directly upstream of the byte-wide memory-mapped FPU.
- Accepts one 32-bit single-precision operation (Y op X; op = divide or multiply) on a word-level request/done handshake.
- Runs the FPU's byte protocol: command/value writes, status polling, and four result reads.
- Returns the 32-bit result, so the CPU or a test sequencer can use the FPU without per-byte software.

---
 rtl/fpu_pkg.sv | 37 +++
 rtl/fpu_driver_if.sv | 36 +++
 rtl/fpu_bus_access.sv | 93 +++++++++
 rtl/fpu_driver.sv | 152 +++++++++++++++
 tb/tb_fpu_driver.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the byte-wide FPU bus master: address/command codes,
// FSM state types and a byte-select helper.
package fpu_pkg;

    localparam logic [1:0] ADDR_ST  = 2'd0;
    localparam logic [1:0] ADDR_RES = 2'd1;
    localparam logic [1:0] ADDR_CMD = 2'd2;
    localparam logic [1:0] ADDR_VAL = 2'd3;

    localparam logic [7:0] CMD_SETY = 8'd1;
    localparam logic [7:0] CMD_SETX = 8'd2;
    localparam logic [7:0] CMD_DIV  = 8'd3;
    localparam logic [7:0] CMD_MUL  = 8'd4;

    localparam int BUSY_BIT = 7;

    typedef enum logic [3:0] {
        S_IDLE, S_CMD_Y, S_VAL_Y, S_CMD_X, S_VAL_X, S_CMD_OP, S_SETTLE,
        S_POLL, S_DRAIN, S_READ, S_DONE, S_ABORT, S_ERR
    } drv_state_e;

    typedef enum logic {
        A_IDLE, A_GAP
    } acc_state_e;

    // Byte idx of a word, idx 0 = most significant byte.
    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
        byte_of = w[7:0];
        case (idx)
            2'd0: byte_of = w[31:24];
            2'd1: byte_of = w[23:16];
            2'd2: byte_of = w[15:8];
            default: byte_of = w[7:0];
        endcase
    endfunction

endpackage

// File: rtl/fpu_driver_if.sv
// Word-level request/done handshake plus the byte-wide FPU bus, bundled.
// Handshake: req is sampled only while the driver is idle (busy=0); done or
// err pulses for one cycle and ends the operation, result is valid from done.
interface fpu_driver_if;
    import fpu_pkg::*;

    logic        req;
    logic        op;
    logic [31:0] y_in;
    logic [31:0] x_in;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] result;
    logic        fpu_sel;
    logic [1:0]  fpu_addr;
    logic        fpu_read;
    logic        fpu_write;
    logic [7:0]  fpu_wdata;
    logic [7:0]  fpu_rdata;
    drv_state_e  dbg_state;
    acc_state_e  dbg_acc;

    modport master (
        input  req, op, y_in, x_in, fpu_rdata,
        output busy, done, err, result, fpu_sel, fpu_addr, fpu_read,
               fpu_write, fpu_wdata, dbg_state, dbg_acc
    );

    modport slave (
        output req, op, y_in, x_in, fpu_rdata,
        input  busy, done, err, result, fpu_sel, fpu_addr, fpu_read,
               fpu_write, fpu_wdata, dbg_state, dbg_acc
    );

endinterface

// File: rtl/fpu_bus_access.sv
// One FPU bus access: a single-cycle strobe in the cycle start is seen while
// idle, then GAP quiet cycles; ack marks the last quiet cycle.
module fpu_bus_access
    import fpu_pkg::*;
#(
    parameter int GAP = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rd,
    input  logic [1:0] addr_in,
    input  logic [7:0] wdata_in,
    output logic       ack,
    output logic [7:0] rdata,
    output logic       fpu_sel,
    output logic       fpu_read,
    output logic       fpu_write,
    output logic [1:0] fpu_addr,
    output logic [7:0] fpu_wdata,
    input  logic [7:0] fpu_rdata,
    output acc_state_e state
);

    localparam logic [7:0] GAP_M1 = 8'(GAP - 1);

    acc_state_e state_q, state_d;
    logic [7:0] gap_cnt_q, gap_cnt_d;
    logic [1:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic       strobe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= A_IDLE;
            gap_cnt_q <= 8'd0;
            addr_q    <= 2'd0;
            wdata_q   <= 8'd0;
            rdata_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        strobe    = 1'b0;
        ack       = 1'b0;
        case (state_q)
            A_IDLE: begin
                if (start) begin
                    strobe    = 1'b1;
                    addr_d    = addr_in;
                    gap_cnt_d = 8'd0;
                    state_d   = A_GAP;
                    if (rd) rdata_d = fpu_rdata;
                    else    wdata_d = wdata_in;
                end
            end
            A_GAP: begin
                if (gap_cnt_q == GAP_M1) begin
                    ack     = 1'b1;
                    state_d = A_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            default: state_d = A_IDLE;
        endcase
    end

    // Strobe cycle presents the new address/data; gaps hold the last ones.
    always_comb begin
        fpu_sel   = strobe;
        fpu_read  = strobe & rd;
        fpu_write = strobe & ~rd;
        fpu_addr  = strobe ? addr_in : addr_q;
        fpu_wdata = (strobe && !rd) ? wdata_in : wdata_q;
    end

    assign rdata = rdata_q;
    assign state = state_q;

endmodule

// File: rtl/fpu_driver.sv
// Sequences a complete FPU operation (operand writes, command, status poll,
// four result reads) over the byte bus and returns the 32-bit result.
module fpu_driver
    import fpu_pkg::*;
#(
    parameter int GAP        = 1,
    parameter int SETTLE     = 2,
    parameter int POLL_LIMIT = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    fpu_driver_if.master bus
);

    localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);
    localparam logic [7:0] POLL_LIM8 = 8'(POLL_LIMIT);

    drv_state_e  state_q, state_d;
    logic [31:0] y_q, y_d, x_q, x_d;
    logic        op_q, op_d;
    logic [1:0]  byte_q, byte_d;
    logic [7:0]  poll_q, poll_d, poll_inc;
    logic [7:0]  wait_q, wait_d;
    logic [31:0] sh_q, sh_d, result_q, result_d;

    logic        acc_start, acc_rd, acc_ack;
    logic [1:0]  acc_addr;
    logic [7:0]  acc_wdata, acc_rdata;
    logic        acc_sel, acc_read, acc_write;
    logic [1:0]  acc_fpu_addr;
    logic [7:0]  acc_fpu_wdata;
    acc_state_e  acc_state;

    fpu_bus_access #(.GAP(GAP)) u_access (
        .clk(clk), .rst_n(rst_n), .start(acc_start), .rd(acc_rd),
        .addr_in(acc_addr), .wdata_in(acc_wdata), .ack(acc_ack), .rdata(acc_rdata),
        .fpu_sel(acc_sel), .fpu_read(acc_read), .fpu_write(acc_write),
        .fpu_addr(acc_fpu_addr), .fpu_wdata(acc_fpu_wdata),
        .fpu_rdata(bus.fpu_rdata), .state(acc_state)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;   y_q <= '0;      x_q <= '0;     op_q <= 1'b0;
            byte_q <= 2'd0;      poll_q <= 8'd0; wait_q <= 8'd0;
            sh_q <= '0;          result_q <= '0;
        end else begin
            state_q <= state_d;  y_q <= y_d;     x_q <= x_d;    op_q <= op_d;
            byte_q <= byte_d;    poll_q <= poll_d; wait_q <= wait_d;
            sh_q <= sh_d;        result_q <= result_d;
        end
    end

    always_comb begin
        state_d = state_q;  y_d = y_q;  x_d = x_q;  op_d = op_q;
        byte_d = byte_q;    poll_d = poll_q;  wait_d = wait_q;
        sh_d = sh_q;        result_d = result_q;
        poll_inc  = (poll_q == 8'hFF) ? 8'hFF : poll_q + 8'd1;
        acc_start = 1'b0;
        acc_rd    = 1'b0;
        acc_addr  = ADDR_CMD;
        acc_wdata = 8'h00;
        case (state_q)
            S_IDLE: begin
                poll_d = 8'd0;
                byte_d = 2'd0;
                wait_d = 8'd0;
                if (bus.req) begin
                    y_d = bus.y_in;  x_d = bus.x_in;  op_d = bus.op;
                    state_d = S_CMD_Y;
                end
            end
            S_CMD_Y: begin
                acc_start = 1'b1;  acc_wdata = CMD_SETY;
                if (acc_ack) state_d = S_VAL_Y;
            end
            S_VAL_Y: begin
                acc_start = 1'b1;  acc_addr = ADDR_VAL;  acc_wdata = byte_of(y_q, byte_q);
                if (acc_ack) begin
                    byte_d = byte_q + 2'd1;
                    if (byte_q == 2'd3) state_d = S_CMD_X;
                end
            end
            S_CMD_X: begin
                acc_start = 1'b1;  acc_wdata = CMD_SETX;
                if (acc_ack) state_d = S_VAL_X;
            end
            S_VAL_X: begin
                acc_start = 1'b1;  acc_addr = ADDR_VAL;  acc_wdata = byte_of(x_q, byte_q);
                if (acc_ack) begin
                    byte_d = byte_q + 2'd1;
                    if (byte_q == 2'd3) state_d = S_CMD_OP;
                end
            end
            S_CMD_OP: begin
                acc_start = 1'b1;  acc_wdata = op_q ? CMD_DIV : CMD_MUL;
                if (acc_ack) state_d = S_SETTLE;
            end
            S_SETTLE, S_DRAIN: begin
                if (wait_q == SETTLE_M1) begin
                    wait_d  = 8'd0;
                    state_d = (state_q == S_SETTLE) ? S_POLL : S_READ;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_POLL: begin
                acc_start = 1'b1;  acc_rd = 1'b1;  acc_addr = ADDR_ST;
                if (acc_ack) begin
                    if (acc_rdata[BUSY_BIT]) begin
                        poll_d = poll_inc;
                        if (poll_inc >= POLL_LIM8) state_d = S_ABORT;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_READ: begin
                acc_start = 1'b1;  acc_rd = 1'b1;  acc_addr = ADDR_RES;
                if (acc_ack) begin
                    sh_d   = {sh_q[23:0], acc_rdata};
                    byte_d = byte_q + 2'd1;
                    // Load result on the final byte so it is valid alongside done.
                    if (byte_q == 2'd3) begin
                        result_d = {sh_q[23:0], acc_rdata};
                        state_d  = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ABORT: begin
                acc_start = 1'b1;  acc_wdata = CMD_SETY;
                if (acc_ack) state_d = S_ERR;
            end
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy      = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
    assign bus.done      = (state_q == S_DONE);
    assign bus.err       = (state_q == S_ERR);
    assign bus.result    = result_q;
    assign bus.fpu_sel   = acc_sel;
    assign bus.fpu_read  = acc_read;
    assign bus.fpu_write = acc_write;
    assign bus.fpu_addr  = acc_fpu_addr;
    assign bus.fpu_wdata = acc_fpu_wdata;
    assign bus.dbg_state = state_q;
    assign bus.dbg_acc   = acc_state;

endmodule

// File: tb/tb_fpu_driver.sv
// Directed bench for fpu_driver with a behavioural byte-wide FPU model,
// result and bus-trace scoreboards, and a bus timing monitor.
module tb_fpu_driver;
    import fpu_pkg::*;

    localparam int GAP = 1;
    localparam int SETTLE = 2;
    localparam int POLL_LIMIT = 255;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fpu_driver_if bus();

    fpu_driver #(.GAP(GAP), .SETTLE(SETTLE), .POLL_LIMIT(POLL_LIMIT)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int chk_cnt = 0;
    int pass_cnt = 0;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    endtask

    // ---------------- FPU model ----------------
    logic [31:0] m_y = '0, m_x = '0, m_res = '0;
    logic        m_tgt_x = 1'b0;
    logic [1:0]  m_ridx = 2'd0;
    int          m_busy_left = 0;
    int          m_busy_cfg = 0;
    logic        m_stuck = 1'b0;
    logic [7:0]  m_res_byte;

    function automatic logic [31:0] fmodel(input logic [31:0] y, input logic [31:0] x, input logic [7:0] c);
        if (c == 8'd3 && y == 32'h40C00000 && x == 32'h40000000) return 32'h40400000;
        if (c == 8'd4 && y == 32'h40400000 && x == 32'h40000000) return 32'h40C00000;
        if (c == 8'd4 && y == 32'h40000000 && x == 32'h40800000) return 32'h41000000;
        if (c == 8'd3 && y == 32'h41000000 && x == 32'h40800000) return 32'h40000000;
        if (c == 8'd3 && y == 32'h3F800000 && x == 32'h3F800000) return 32'h3F800000;
        return 32'hDEADBEEF;
    endfunction

    always_comb begin
        m_res_byte = m_res[7:0];
        case (m_ridx)
            2'd0: m_res_byte = m_res[31:24];
            2'd1: m_res_byte = m_res[23:16];
            2'd2: m_res_byte = m_res[15:8];
            default: m_res_byte = m_res[7:0];
        endcase
    end

    assign bus.fpu_rdata = (bus.fpu_addr == 2'd0) ? ((m_stuck || m_busy_left != 0) ? 8'h80 : 8'h00)
                         : (bus.fpu_addr == 2'd1) ? m_res_byte : 8'h00;

    always @(posedge clk) begin
        if (bus.fpu_sel && bus.fpu_write) begin
            if (bus.fpu_addr == 2'd2) begin
                if (bus.fpu_wdata == 8'd1) m_tgt_x <= 1'b0;
                else if (bus.fpu_wdata == 8'd2) m_tgt_x <= 1'b1;
                else if (bus.fpu_wdata == 8'd3 || bus.fpu_wdata == 8'd4) begin
                    m_res       <= fmodel(m_y, m_x, bus.fpu_wdata);
                    m_ridx      <= 2'd0;
                    m_busy_left <= m_busy_cfg;
                end
            end else if (bus.fpu_addr == 2'd3) begin
                if (m_tgt_x) m_x <= {m_x[23:0], bus.fpu_wdata};
                else         m_y <= {m_y[23:0], bus.fpu_wdata};
            end
        end else if (bus.fpu_sel && bus.fpu_read) begin
            if (bus.fpu_addr == 2'd0 && m_busy_left > 0) m_busy_left <= m_busy_left - 1;
            if (bus.fpu_addr == 2'd1) m_ridx <= m_ridx + 2'd1;
        end
    end

    // ---------------- scoreboards ----------------
    logic [32:0] exp_q[$];      // {is_err, result}
    logic [10:0] bus_exp_q[$];  // {is_write, addr, wdata}

    task automatic push_w(input logic [1:0] a, input logic [7:0] d);
        bus_exp_q.push_back({1'b1, a, d});
    endtask

    task automatic push_r(input logic [1:0] a);
        bus_exp_q.push_back({1'b0, a, 8'h00});
    endtask

    task automatic push_trace(input logic op_i, input logic [31:0] y, input logic [31:0] x);
        push_w(2'd2, 8'd1);
        push_w(2'd3, y[31:24]); push_w(2'd3, y[23:16]); push_w(2'd3, y[15:8]); push_w(2'd3, y[7:0]);
        push_w(2'd2, 8'd2);
        push_w(2'd3, x[31:24]); push_w(2'd3, x[23:16]); push_w(2'd3, x[15:8]); push_w(2'd3, x[7:0]);
        push_w(2'd2, op_i ? 8'd3 : 8'd4);
    endtask

    // Result monitor
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (rst_n && (bus.done || bus.err)) begin
            logic [32:0] e;
            if (exp_q.size() == 0) begin
                check(1'b0, "unexpected_done_err", {30'd0, bus.err, bus.done}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check(bus.err == e[32] && bus.done == !e[32], "done_err_kind",
                      {30'd0, bus.err, bus.done}, {30'd0, e[32], !e[32]});
                check(bus.result == e[31:0], "result", bus.result, e[31:0]);
                check(bus.busy == 1'b0, "busy_at_end", {31'd0, bus.busy}, 32'd0);
            end
            if (bus.done) check(!prev_done, "done_single_pulse", {31'd0, prev_done}, 32'd0);
        end
        prev_done <= rst_n && bus.done;
    end

    // Bus monitor: trace and strobe timing
    int  low_run = 100;
    int  since_cmd = 0;
    int  since_st = 0;
    bit  cmd_pending = 0;
    bit  drain_pending = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            low_run = 100; cmd_pending = 0; drain_pending = 0;
        end else if (bus.fpu_sel) begin
            logic [10:0] e;
            check(low_run >= GAP, "strobe_gap", 32'(low_run), 32'(GAP));
            check(bus.fpu_read ^ bus.fpu_write, "strobe_rw_onehot",
                  {30'd0, bus.fpu_read, bus.fpu_write}, 32'd1);
            if (bus_exp_q.size() == 0) begin
                check(1'b0, "unexpected_strobe", {21'd0, bus.fpu_write, bus.fpu_addr, bus.fpu_wdata}, 32'd0);
            end else begin
                e = bus_exp_q.pop_front();
                check(bus.fpu_write == e[10] && bus.fpu_addr == e[9:8], "bus_access_kind",
                      {29'd0, bus.fpu_write, bus.fpu_addr}, {29'd0, e[10:8]});
                if (e[10]) check(bus.fpu_wdata == e[7:0], "bus_wdata", {24'd0, bus.fpu_wdata}, {24'd0, e[7:0]});
            end
            if (bus.fpu_read && bus.fpu_addr == 2'd0) begin
                if (cmd_pending) check(since_cmd >= SETTLE, "settle_before_poll", 32'(since_cmd), 32'(SETTLE));
                cmd_pending = 0; drain_pending = 1; since_st = 0;
            end
            if (bus.fpu_read && bus.fpu_addr == 2'd1 && drain_pending) begin
                check(since_st >= SETTLE + GAP, "drain_before_read", 32'(since_st), 32'(SETTLE + GAP));
                drain_pending = 0;
            end
            if (bus.fpu_write && bus.fpu_addr == 2'd2 && (bus.fpu_wdata == 8'd3 || bus.fpu_wdata == 8'd4)) begin
                cmd_pending = 1; since_cmd = 0;
            end
            low_run = 0;
        end else begin
            low_run++; since_cmd++; since_st++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_op(input logic op_i, input logic [31:0] y, input logic [31:0] x,
                          input logic [31:0] exp_res, input int polls, input logic stuck,
                          input logic [31:0] prev_res);
        int cnt;
        m_busy_cfg = polls;
        m_stuck    = stuck;
        push_trace(op_i, y, x);
        if (stuck) begin
            for (int i = 0; i < POLL_LIMIT; i++) push_r(2'd0);
            push_w(2'd2, 8'd1);
            exp_q.push_back({1'b1, prev_res});
        end else begin
            for (int i = 0; i <= polls; i++) push_r(2'd0);
            for (int i = 0; i < 4; i++) push_r(2'd1);
            exp_q.push_back({1'b0, exp_res});
        end
        @(negedge clk);
        bus.req = 1'b1; bus.op = op_i; bus.y_in = y; bus.x_in = x;
        @(negedge clk);
        bus.req = 1'b0;
        check(bus.busy == 1'b1, "busy_after_accept", {31'd0, bus.busy}, 32'd1);
        cnt = 1;
        while (!(bus.done || bus.err) && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 2000) check(1'b0, "done_timeout", 32'(cnt), 32'd2000);
        else if (!stuck) check(cnt == 37 + 2 * polls, "latency", 32'(cnt), 32'(37 + 2 * polls));
        repeat (4) @(negedge clk);
        m_stuck = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        bus.req = 1'b0; bus.op = 1'b0; bus.y_in = '0; bus.x_in = '0;
        repeat (3) @(negedge clk);
        check({bus.busy, bus.done, bus.err, bus.fpu_sel, bus.fpu_read, bus.fpu_write} == 6'd0,
              "reset_strobes_flags", {26'd0, bus.busy, bus.done, bus.err, bus.fpu_sel, bus.fpu_read, bus.fpu_write}, 32'd0);
        check(bus.result == 32'd0, "reset_result", bus.result, 32'd0);
        check({bus.fpu_addr, bus.fpu_wdata} == 10'd0, "reset_addr_wdata", {22'd0, bus.fpu_addr, bus.fpu_wdata}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check(bus.busy == 1'b0 && bus.fpu_sel == 1'b0, "idle_after_reset", {30'd0, bus.busy, bus.fpu_sel}, 32'd0);

        run_op(1'b1, 32'h40C00000, 32'h40000000, 32'h40400000, 0, 1'b0, 32'd0);   // 6/2
        run_op(1'b0, 32'h40400000, 32'h40000000, 32'h40C00000, 0, 1'b0, 32'd0);   // 3*2
        run_op(1'b0, 32'h40000000, 32'h40800000, 32'h41000000, 3, 1'b0, 32'd0);   // 2*4, 3 busy polls
        run_op(1'b1, 32'h40C00000, 32'h40000000, 32'd0, 0, 1'b1, 32'h41000000);   // stuck busy
        check(bus.result == 32'h41000000, "result_held_after_err", bus.result, 32'h41000000);

        // req held high through the operation with operands changed mid-flight.
        m_busy_cfg = 1;
        push_trace(1'b1, 32'h41000000, 32'h40800000);
        for (int i = 0; i < 2; i++) push_r(2'd0);
        for (int i = 0; i < 4; i++) push_r(2'd1);
        exp_q.push_back({1'b0, 32'h40000000});
        @(negedge clk);
        bus.req = 1'b1; bus.op = 1'b1; bus.y_in = 32'h41000000; bus.x_in = 32'h40800000;
        repeat (5) @(negedge clk);
        bus.op = 1'b0; bus.y_in = 32'h3F800000; bus.x_in = 32'h3F800000;
        cnt = 0;
        while (!bus.done && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 200) check(1'b0, "held_req_timeout", 32'(cnt), 32'd200);
        bus.req = 1'b0;
        repeat (30) @(negedge clk);
        check(bus.busy == 1'b0, "no_second_op", {31'd0, bus.busy}, 32'd0);

        // Reset while a value byte for X is on the bus.
        m_busy_cfg = 0;
        push_trace(1'b1, 32'h40C00000, 32'h40000000);
        exp_q.push_back({1'b0, 32'hFFFFFFFF});
        @(negedge clk);
        bus.req = 1'b1; bus.op = 1'b1; bus.y_in = 32'h40C00000; bus.x_in = 32'h40000000;
        @(negedge clk);
        bus.req = 1'b0;
        cnt = 0;
        while (!(bus.dbg_state == S_VAL_X && bus.fpu_write) && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 100) check(1'b0, "reach_val_x_timeout", 32'(cnt), 32'd100);
        #1 rst_n = 1'b0;
        #1;
        check({bus.fpu_sel, bus.fpu_read, bus.fpu_write, bus.busy, bus.done} == 5'd0, "reset_mid_op",
              {27'd0, bus.fpu_sel, bus.fpu_read, bus.fpu_write, bus.busy, bus.done}, 32'd0);
        bus_exp_q.delete();
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_op(1'b1, 32'h3F800000, 32'h3F800000, 32'h3F800000, 0, 1'b0, 32'd0);   // 1/1

        check(bus_exp_q.size() == 0, "bus_trace_drained", 32'(bus_exp_q.size()), 32'd0);
        check(exp_q.size() == 0, "results_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
